// File: rtl/ssd_mux_driver_pkg.sv
// Shared definitions for the seven-segment multiplex driver: FSM state
// encodings, the segment-off constant and the hex segment table.
package ssd_mux_driver_pkg;

    typedef enum logic [1:0] {
        StShowR  = 2'd0,
        StBlankL = 2'd1,
        StShowL  = 2'd2,
        StBlankR = 2'd3
    } state_e;

    // Segments are {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SegOff = 7'h00;

    // Index 0 is the rightmost entry.
    localparam logic [15:0][6:0] SegTable = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/ssd_mux_driver_hex_to_7seg.sv
// Combinational hex digit to seven-segment decoder (active-high segments).
module hex_to_7seg
    import ssd_mux_driver_pkg::*;
(
    input  logic [3:0] hex_in,
    output logic [6:0] seg_out
);

    // Straight table lookup.
    always_comb begin
        seg_out = SegTable[hex_in];
    end

endmodule

// File: rtl/ssd_mux_driver.sv
// Two-digit PmodSSD multiplex driver. Each edge of the asynchronous mux
// square wave swaps the lit digit, with DEADTIME cycles of blanking around
// every select change. New values are double-buffered and only committed at
// the frame boundary (end of BLANK_R).
// Optional build macro: SSD_LEADING_ZERO_BLANK_EN blanks a zero left digit.
module ssd_mux_driver
    import ssd_mux_driver_pkg::*;
#(
    parameter int unsigned DEADTIME       = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       mux_clk_in,
    input  logic [7:0] value_in,
    input  logic       load_in,
    output logic       ready_out,
    output logic [6:0] seg_out,
    output logic       sel_out
);

    localparam logic [15:0] DeadLast = 16'(DEADTIME - 1);
    localparam logic [6:0]  SegRst   = SEG_ACTIVE_LOW ? ~SegOff : SegOff;

    logic        sync1_q, sync2_q, prev_q;
    logic        swap;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        commit;
    logic        accept;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  disp_q, disp_d;
    logic        ready_q, ready_d;
    logic [3:0]  digit;
    logic [6:0]  dec_seg;
    logic [6:0]  seg_d, seg_q;
    logic        sel_d, sel_q;

    // Two-flop synchroniser plus an edge-detect flop on the mux clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= mux_clk_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Either edge of the synchronised mux clock is a swap request.
    assign swap = sync2_q ^ prev_q;

    // Next-state logic; swaps seen while blanking are simply dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StShowR: begin
                if (swap) begin
                    state_d = StBlankL;
                    cnt_d   = '0;
                end
            end
            StBlankL: begin
                if (cnt_q == DeadLast) begin
                    state_d = StShowL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StShowL: begin
                if (swap) begin
                    state_d = StBlankR;
                    cnt_d   = '0;
                end
            end
            StBlankR: begin
                if (cnt_q == DeadLast) begin
                    state_d = StShowR;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StShowR;
                cnt_d   = '0;
            end
        endcase
    end

    // Load handshake and frame-boundary commit. A capture needs ready_q, so a
    // load colliding with a pending commit is ignored.
    always_comb begin
        accept  = load_in && ready_q;
        pend_d  = accept ? value_in : pend_q;
        disp_d  = commit ? pend_q : disp_q;
        ready_d = ready_q;
        if (accept) begin
            ready_d = 1'b0;
        end else if (commit) begin
            ready_d = 1'b1;
        end
    end

    assign digit = (state_q == StShowL) ? disp_q[7:4] : disp_q[3:0];

    hex_to_7seg u_hex_to_7seg (
        .hex_in  (digit),
        .seg_out (dec_seg)
    );

    // Output decode from the current state; registered below.
    always_comb begin
        seg_d = SegOff;
        sel_d = (state_q == StBlankL) || (state_q == StShowL);
        unique case (state_q)
            StShowR: seg_d = dec_seg;
`ifdef SSD_LEADING_ZERO_BLANK_EN
            StShowL: seg_d = (disp_q[7:4] == 4'h0) ? SegOff : dec_seg;
`else
            StShowL: seg_d = dec_seg;
`endif
            default: seg_d = SegOff;
        endcase
    end

    // State, data and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StShowR;
            cnt_q   <= '0;
            pend_q  <= 8'h00;
            disp_q  <= 8'h00;
            ready_q <= 1'b1;
            seg_q   <= SegRst;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            ready_q <= ready_d;
            seg_q   <= SEG_ACTIVE_LOW ? ~seg_d : seg_d;
            sel_q   <= sel_d;
        end
    end

    assign seg_out   = seg_q;
    assign sel_out   = sel_q;
    assign ready_out = ready_q;

endmodule
